// File: rtl/mmcm_ps_servo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mmcm_ps_servo: closed-loop MMCM dynamic phase-shift servo (PSCLK domain).  |
// | Optional lock detect: define MMCM_PS_SERVO_LOCK_DETECT_EN.                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mmcm_ps_servo #(
  parameter int WIN_LOG2     = 8,
  parameter int THRESH       = 16,
  parameter int POS_W        = 16,
  parameter int POS_MAX      = 1120,
  parameter int TIMEOUT      = 64,
  parameter int LOCK_WINDOWS = 4
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic                    enable,
  input  logic                    mmcm_locked,
  input  logic                    pd_valid,
  input  logic                    pd_late,
  output logic                    psen,
  output logic                    psincdec,
  input  logic                    psdone,
  output logic signed [POS_W-1:0] phase_pos,
  output logic                    at_limit,
  output logic                    timeout_err,
  output logic                    in_lock
);

  localparam int ACC_W = WIN_LOG2 + 2;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic signed [ACC_W-1:0] C_THRESH_P = ACC_W'(THRESH);
  localparam logic signed [ACC_W-1:0] C_THRESH_N = ACC_W'(-THRESH);
  localparam logic signed [POS_W-1:0] C_POS_MAX  = POS_W'(POS_MAX);
  localparam logic signed [POS_W-1:0] C_POS_MIN  = POS_W'(-POS_MAX);
  localparam logic [WIN_LOG2-1:0]     C_WIN_LAST = '1;
  localparam logic [TMO_W-1:0]        C_TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCUM  = 3'd1,
    S_DECIDE = 3'd2,
    S_STEP   = 3'd3,
    S_WAIT   = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [WIN_LOG2-1:0]      win_cnt_q, win_cnt_d;
  logic [TMO_W-1:0]         tmo_cnt_q, tmo_cnt_d;
  logic signed [POS_W-1:0]  pos_q, pos_d;
  logic                     incdec_q, incdec_d;
  logic                     at_limit_q, at_limit_d;
  logic                     tmo_err_q, tmo_err_d;
  logic                     w_run, w_up, w_dn;

  assign w_run = enable & mmcm_locked;
  assign w_up  = (acc_q >= C_THRESH_P);
  assign w_dn  = (acc_q <= C_THRESH_N);

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    win_cnt_d  = win_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    pos_d      = pos_q;
    incdec_d   = incdec_q;
    at_limit_d = at_limit_q;
    tmo_err_d  = tmo_err_q & enable;
    psen       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_run) begin
          state_d   = S_ACCUM;
          acc_d     = '0;
          win_cnt_d = '0;
        end
      end
      S_ACCUM: begin
        if (!w_run) begin
          state_d = S_IDLE;
        end else begin
          if (pd_valid) acc_d = pd_late ? acc_q + ACC_W'(1) : acc_q - ACC_W'(1);
          win_cnt_d = win_cnt_q + WIN_LOG2'(1);
          if (win_cnt_q == C_WIN_LAST) state_d = S_DECIDE;
        end
      end
      S_DECIDE: begin
        if (!w_run) begin
          state_d = S_IDLE;
        end else if (w_up && (pos_q < C_POS_MAX)) begin
          state_d    = S_STEP;
          incdec_d   = 1'b1;
          at_limit_d = 1'b0;
        end else if (w_dn && (pos_q > C_POS_MIN)) begin
          state_d    = S_STEP;
          incdec_d   = 1'b0;
          at_limit_d = 1'b0;
        end else begin
          at_limit_d = w_up | w_dn;
          state_d    = S_ACCUM;
          acc_d      = '0;
          win_cnt_d  = '0;
        end
      end
      S_STEP: begin
        tmo_cnt_d = '0;
        // Lock may vanish after DECIDE; never pulse PSEN into an unlocked MMCM.
        if (mmcm_locked) begin
          psen    = 1'b1;
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (psdone) begin
          pos_d = incdec_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
          if (w_run) begin
            state_d   = S_ACCUM;
            acc_d     = '0;
            win_cnt_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else if (tmo_cnt_q == C_TMO_LAST) begin
          tmo_err_d = enable;
          state_d   = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      win_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      pos_q      <= '0;
      incdec_q   <= 1'b0;
      at_limit_q <= 1'b0;
      tmo_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      win_cnt_q  <= win_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      pos_q      <= pos_d;
      incdec_q   <= incdec_d;
      at_limit_q <= at_limit_d;
      tmo_err_q  <= tmo_err_d;
    end
  end

  assign psincdec    = incdec_q;
  assign phase_pos   = pos_q;
  assign at_limit    = at_limit_q;
  assign timeout_err = tmo_err_q;

`ifdef MMCM_PS_SERVO_LOCK_DETECT_EN
  localparam int QW = $clog2(LOCK_WINDOWS + 1);
  localparam logic [QW-1:0] C_LOCK_N = QW'(LOCK_WINDOWS);

  logic [QW-1:0] quiet_q, quiet_d;
  logic          w_quiet;

  assign w_quiet = (state_q == S_DECIDE) && w_run && !(w_up || w_dn);

  always_comb begin
    quiet_d = quiet_q;
    if ((state_d == S_STEP) || (state_d == S_IDLE)) begin
      quiet_d = '0;
    end else if (w_quiet && (quiet_q != C_LOCK_N)) begin
      quiet_d = quiet_q + QW'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) quiet_q <= '0;
    else          quiet_q <= quiet_d;
  end

  assign in_lock = (quiet_q == C_LOCK_N);
`else
  assign in_lock = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mmcm_ps_servo.sv
`default_nettype none
// Randomized self-checking bench for mmcm_ps_servo against a window-level reference model.
module tb_mmcm_ps_servo;
  localparam int WIN_LOG2 = 4, WIN = 16, THRESH = 8, POS_W = 16;
  localparam int POS_MAX = 2, TIMEOUT = 64, LOCK_WINDOWS = 4;

  logic clk_in = 1'b0;
  logic reset_in, enable, mmcm_locked, pd_valid, pd_late, psdone;
  logic psen, psincdec, at_limit, timeout_err, in_lock;
  logic signed [POS_W-1:0] phase_pos;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_pos  = 0;
  bit exp_lim  = 1'b0;
  int exp_quiet = 0;

  always #5 clk_in = ~clk_in;

  mmcm_ps_servo #(
    .WIN_LOG2(WIN_LOG2), .THRESH(THRESH), .POS_W(POS_W),
    .POS_MAX(POS_MAX), .TIMEOUT(TIMEOUT), .LOCK_WINDOWS(LOCK_WINDOWS)
  ) u_dut (
    .clk_in(clk_in), .reset_in(reset_in), .enable(enable), .mmcm_locked(mmcm_locked),
    .pd_valid(pd_valid), .pd_late(pd_late), .psen(psen), .psincdec(psincdec),
    .psdone(psdone), .phase_pos(phase_pos), .at_limit(at_limit),
    .timeout_err(timeout_err), .in_lock(in_lock)
  );

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic bit exp_lock();
`ifdef MMCM_PS_SERVO_LOCK_DETECT_EN
    return exp_quiet >= LOCK_WINDOWS;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int push_mode();
    return (exp_pos < POS_MAX) ? 0 : 1;
  endfunction

  // Drives one full window of phase-detector samples; returns the net late-minus-early count.
  task automatic run_accum(input int mode, output int sum);
    int bad = 0;
    bit v, l;
    sum = 0;
    for (int i = 0; i < WIN; i++) begin
      case (mode)
        0: begin v = 1'b1; l = 1'b1; end
        1: begin v = 1'b1; l = 1'b0; end
        2: begin v = 1'b1; l = (i % 2 == 0); end
        3: begin v = ($urandom_range(0, 1) == 1); l = ($urandom_range(0, 1) == 1); end
        4: begin v = 1'b1; l = ($urandom_range(0, 9) != 0); end
        default: begin v = 1'b1; l = ($urandom_range(0, 9) == 0); end
      endcase
      pd_valid = v;
      pd_late  = l;
      psdone   = ($urandom_range(0, 3) == 0);
      if (v) sum += l ? 1 : -1;
      if (psen !== 1'b0) bad++;
      tick();
    end
    pd_valid = ($urandom_range(0, 1) == 1);
    pd_late  = ($urandom_range(0, 1) == 1);
    psdone   = ($urandom_range(0, 1) == 1);
    check("psen_quiet_in_window", bad, 0);
  endtask

  task automatic decide_model(input int sum, output bit step, output bit dir);
    step = 1'b0;
    dir  = 1'b0;
    if (sum >= THRESH && exp_pos < POS_MAX) begin
      step = 1'b1; dir = 1'b1; exp_lim = 1'b0;
    end else if (sum <= -THRESH && exp_pos > -POS_MAX) begin
      step = 1'b1; dir = 1'b0; exp_lim = 1'b0;
    end else if (sum >= THRESH || sum <= -THRESH) begin
      exp_lim = 1'b1;
    end else begin
      exp_lim = 1'b0;
      if (exp_quiet < LOCK_WINDOWS) exp_quiet++;
    end
    if (step) exp_quiet = 0;
  endtask

  // Called in the first WAIT cycle; dly=0 means psdone is never returned.
  task automatic serve_wait(input int dly, input bit dir);
    int bad = 0;
    if (dly > 0) begin
      for (int j = 0; j < dly - 1; j++) begin
        psdone = 1'b0;
        if (psen !== 1'b0) bad++;
        tick();
      end
      psdone = 1'b1;
      if (psen !== 1'b0 || psincdec !== dir) bad++;
      tick();
      psdone = 1'b0;
      exp_pos += dir ? 1 : -1;
      check("wait_psen_psincdec", bad, 0);
      check("phase_pos_after_done", phase_pos, exp_pos);
      check("in_lock_after_step", in_lock, exp_lock());
    end else begin
      for (int j = 0; j < TIMEOUT - 1; j++) begin
        psdone = 1'b0;
        if (psen !== 1'b0) bad++;
        tick();
      end
      check("timeout_not_early", timeout_err, 0);
      tick();
      exp_quiet = 0;
      check("timeout_err_set", timeout_err, 1);
      check("phase_pos_on_timeout", phase_pos, exp_pos);
      check("wait_psen_timeout", bad, 0);
    end
  endtask

  // Entered with the DUT in its first ACCUM cycle.
  task automatic window(input int mode, input int dly);
    int sum;
    bit step, dir;
    run_accum(mode, sum);
    decide_model(sum, step, dir);
    tick();
    check("psen_after_decide", psen, step);
    if (step) begin
      check("psincdec_on_psen", psincdec, dir);
      psdone = 1'b0;
      tick();
      serve_wait(dly, dir);
    end else begin
      check("at_limit", at_limit, exp_lim);
      check("phase_pos_hold", phase_pos, exp_pos);
      check("in_lock", in_lock, exp_lock());
    end
  endtask

  initial begin
    int sum, k, bad;
    bit step, dir;
    reset_in = 1'b1; enable = 1'b0; mmcm_locked = 1'b0;
    pd_valid = 1'b0; pd_late = 1'b0; psdone = 1'b0;
    repeat (3) tick();
    check("rst_psen", psen, 0);
    check("rst_psincdec", psincdec, 0);
    check("rst_phase_pos", phase_pos, 0);
    check("rst_at_limit", at_limit, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_in_lock", in_lock, 0);

    reset_in = 1'b0; enable = 1'b1; mmcm_locked = 1'b1;
    tick();

    // Increment to the upper limit, then walk down to the lower limit.
    window(0, 3);
    window(0, 3);
    window(0, 3);
    window(1, 2);
    window(1, 1);
    window(1, TIMEOUT);
    window(1, 4);
    window(1, 2);

    for (int w = 0; w < 10; w++) window(2, 1);

    for (int w = 0; w < 20; w++) window($urandom_range(0, 5), $urandom_range(1, 6));

    // Timeout, stickiness, and clear by enable.
    window(push_mode(), 0);
    tick();
    check("timeout_err_sticky", timeout_err, 1);
    enable = 1'b0;
    tick();
    check("timeout_err_cleared", timeout_err, 0);
    enable = 1'b1;
    tick();
    window(push_mode(), 2);

    // Run request dropped mid-window.
    k = $urandom_range(3, 10);
    bad = 0;
    for (int i = 0; i < k; i++) begin
      pd_valid = 1'b1; pd_late = 1'b1;
      if (psen !== 1'b0) bad++;
      tick();
    end
    if ($urandom_range(0, 1) == 1) mmcm_locked = 1'b0;
    else enable = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      if (psen !== 1'b0) bad++;
      tick();
    end
    check("psen_drop_in_accum", bad, 0);
    mmcm_locked = 1'b1; enable = 1'b1; exp_quiet = 0;
    tick();
    window(push_mode(), 2);

    // Lock lost during DECIDE: no step.
    run_accum(push_mode(), sum);
    mmcm_locked = 1'b0;
    tick();
    check("psen_drop_in_decide", psen, 0);
    tick();
    check("psen_idle_unlocked", psen, 0);
    mmcm_locked = 1'b1; exp_quiet = 0;
    tick();
    window(push_mode(), 3);

    // Lock lost during WAIT: psdone still counted, then idle.
    run_accum(push_mode(), sum);
    decide_model(sum, step, dir);
    tick();
    check("psen_before_wait_drop", psen, step);
    psdone = 1'b0;
    tick();
    mmcm_locked = 1'b0;
    tick();
    psdone = 1'b1;
    tick();
    psdone = 1'b0;
    exp_pos += dir ? 1 : -1;
    exp_quiet = 0;
    check("phase_pos_drop_in_wait", phase_pos, exp_pos);
    check("psen_after_wait_drop", psen, 0);
    tick();
    check("psen_idle_after_wait_drop", psen, 0);
    mmcm_locked = 1'b1;
    tick();
    window(push_mode(), 1);

    // Reset in the middle of WAIT.
    run_accum(push_mode(), sum);
    decide_model(sum, step, dir);
    tick();
    psdone = 1'b0;
    tick();
    tick();
    reset_in = 1'b1;
    tick();
    check("midwait_rst_psen", psen, 0);
    check("midwait_rst_phase_pos", phase_pos, 0);
    check("midwait_rst_psincdec", psincdec, 0);
    check("midwait_rst_at_limit", at_limit, 0);
    reset_in = 1'b0;
    exp_pos = 0; exp_lim = 1'b0; exp_quiet = 0;
    tick();
    window(0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
